// File: rtl/ptp_pkg.sv
// Shared widths, capture states and type limits for the PTP receive
// timestamp queue.
package ptp_pkg;

    localparam int TS_SEC_W   = 48;
    localparam int TS_NS_W    = 30;
    localparam int SRC_PORT_W = 80;
    localparam int REC_W      = 178;

    localparam int TS_W  = TS_SEC_W + TS_NS_W;
    localparam int HDR_W = 4 + 16 + SRC_PORT_W;

    localparam logic [3:0] EVT_TYPE_MAX = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_STAGED
    } cap_state_e;

endpackage

// File: rtl/ptp_sync_fifo.sv
// Register FIFO with a show-ahead head; a pop frees a slot for a
// same-cycle push even when full.
module ptp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ptp_rx_ts_fifo.sv
// Receive-side PTP timestamp capture: stamps SFD time, pairs it with the
// parsed header and queues the record only for frames ending cleanly.
module ptp_rx_ts_fifo
    import ptp_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter bit EVENT_ONLY = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sof_i,
    input  logic                    eof_i,
    input  logic                    frame_err_i,
    input  logic [TS_SEC_W-1:0]     rtc_sec_i,
    input  logic [TS_NS_W-1:0]      rtc_ns_i,
    input  logic                    ptp_valid_i,
    input  logic [3:0]              ptp_msg_type_i,
    input  logic [15:0]             ptp_seq_id_i,
    input  logic [SRC_PORT_W-1:0]   ptp_src_port_i,
    input  logic                    rd_en_i,
    input  logic                    clr_ovf_i,
    output logic                    rd_valid_o,
    output logic [REC_W-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    ovf_o,
    output logic [7:0]              drop_cnt_o
);

    cap_state_e       state_q, state_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [HDR_W-1:0] hdr_q, hdr_d;
    logic [HDR_W-1:0] in_hdr;
    logic [HDR_W-1:0] commit_hdr;
    logic             hdr_hit;
    logic             commit;
    logic             full;
    logic             empty;
    logic             drop;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;

    assign in_hdr  = {ptp_msg_type_i, ptp_seq_id_i, ptp_src_port_i};
    assign hdr_hit = ptp_valid_i &&
                     (!EVENT_ONLY || (ptp_msg_type_i <= EVT_TYPE_MAX));

    // eof closes the old frame before a same-cycle sof opens the next one
    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q;
        hdr_d      = hdr_q;
        commit     = 1'b0;
        commit_hdr = hdr_q;
        unique case (state_q)
            ST_FRAME: begin
                if (hdr_hit) begin
                    hdr_d   = in_hdr;
                    state_d = ST_STAGED;
                end
                if (eof_i) begin
                    commit     = hdr_hit && !frame_err_i;
                    commit_hdr = in_hdr;
                    state_d    = ST_IDLE;
                end
            end
            ST_STAGED: begin
                if (eof_i) begin
                    commit  = !frame_err_i;
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (sof_i) begin
            ts_d    = {rtc_sec_i, rtc_ns_i};
            state_d = ST_FRAME;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            hdr_q   <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            hdr_q   <= hdr_d;
        end
    end

    ptp_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (commit),
        .data_i  ({commit_hdr, ts_q}),
        .pop_i   (rd_en_i),
        .data_o  (rd_data_o),
        .count_o (count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // full implies non-empty, so rd_en always frees the slot
    assign drop = commit && full && !rd_en_i;

    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr_ovf_i) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign rd_valid_o = !empty;
    assign ovf_o      = ovf_q;
    assign drop_cnt_o = drop_q;

endmodule
